// File: rtl/hc595_pkg.sv
// Shared types and constants for the 74HC595 chain controller.
// hc595_period() gives the handshake-to-handshake spacing in i_clk cycles.
package hc595_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } hc595_state_t;

  localparam int HC595_CHAIN_BITS = 8;
  localparam int HC595_CLK_DIV    = 1;

  function automatic int hc595_period(input int chain_bits, input int clk_div);
    return 2 * chain_bits * clk_div + clk_div + 1;
  endfunction

endpackage

// File: rtl/hc595_rr_arb.sv
// Two-way round-robin arbiter: the pointer picks the winner only under contention
// and flips whenever a contended grant is taken.
module hc595_rr_arb (
  input  logic i_clk,
  input  logic i_rst,
  input  logic valid0,
  input  logic valid1,
  input  logic advance,
  output logic gnt_valid,
  output logic gnt_idx
);

  logic ptr_reg;

  always_comb begin
    gnt_valid = valid0 | valid1;
    gnt_idx   = (valid0 & valid1) ? ptr_reg : valid1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_reg <= 1'b0;
    end else if (advance & valid0 & valid1) begin
      ptr_reg <= ~ptr_reg;
    end
  end

endmodule

// File: rtl/hc595_chain_arbiter.sv
// Shares one 74HC595 chain between two valid/ready requesters: grants round-robin,
// shifts the word out LSB first on SRCLK/SER, pulses RCLK, then drives OE.
module hc595_chain_arbiter
  import hc595_pkg::*;
#(
  parameter int CHAIN_BITS = HC595_CHAIN_BITS,
  parameter int CLK_DIV    = HC595_CLK_DIV
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0_valid,
  input  logic [CHAIN_BITS-1:0] i_req0_data,
  output logic                  o_req0_ready,
  input  logic                  i_req1_valid,
  input  logic [CHAIN_BITS-1:0] i_req1_data,
  output logic                  o_req1_ready,
  input  logic                  i_oe_en,
  output logic                  o_busy,
  output logic                  o_grant,
  output logic                  o_clk,
  output logic                  o_latch,
  output logic                  o_data,
  output logic                  o_oe_
);

  localparam int PW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(CHAIN_BITS + 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(CHAIN_BITS - 1);

  hc595_state_t          state_reg, state_next;
  logic [CHAIN_BITS-1:0] shift_reg, shift_next;
  logic [PW-1:0]         phase_reg, phase_next;
  logic [BW-1:0]         bit_reg, bit_next;
  logic                  grant_reg, grant_next;
  logic                  loaded_reg, loaded_next;
  logic                  oe_n_reg;

  logic [1:0]            valid_vec, ready_vec;
  logic [CHAIN_BITS-1:0] data_vec [2];
  logic                  gnt_valid, gnt_idx;
  logic                  hs, phase_last;

  assign valid_vec   = {i_req1_valid, i_req0_valid};
  assign data_vec[0] = i_req0_data;
  assign data_vec[1] = i_req1_data;

  hc595_rr_arb u_arb (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .valid0    (valid_vec[0]),
    .valid1    (valid_vec[1]),
    .advance   (hs),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Ready is only offered to the requester the arbiter is currently pointing at.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign ready_vec[gi] = (state_reg == IDLE) & ~i_rst & gnt_valid & (gnt_idx == 1'(gi));
    end
  endgenerate

  assign hs           = |ready_vec;
  assign o_req0_ready = ready_vec[0];
  assign o_req1_ready = ready_vec[1];
  assign phase_last   = (phase_reg == PHASE_LAST);

  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    phase_next  = phase_reg;
    bit_next    = bit_reg;
    grant_next  = grant_reg;
    loaded_next = loaded_reg;
    unique case (state_reg)
      IDLE: begin
        phase_next = '0;
        bit_next   = '0;
        if (hs) begin
          shift_next = data_vec[gnt_idx];
          grant_next = gnt_idx;
          state_next = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (phase_last) begin
          phase_next = '0;
          state_next = SHIFT_HI;
        end else begin
          phase_next = phase_reg + 1'b1;
        end
      end
      SHIFT_HI: begin
        // SER only moves after the high half, so it stays stable around the rising edge.
        if (phase_last) begin
          phase_next = '0;
          shift_next = shift_reg >> 1;
          if (bit_reg == BIT_LAST) begin
            state_next = LATCH;
          end else begin
            bit_next   = bit_reg + 1'b1;
            state_next = SHIFT_LO;
          end
        end else begin
          phase_next = phase_reg + 1'b1;
        end
      end
      LATCH: begin
        if (phase_last) begin
          phase_next  = '0;
          loaded_next = 1'b1;
          state_next  = IDLE;
        end else begin
          phase_next = phase_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      phase_reg  <= '0;
      bit_reg    <= '0;
      grant_reg  <= 1'b0;
      loaded_reg <= 1'b0;
      oe_n_reg   <= 1'b1;
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      phase_reg  <= phase_next;
      bit_reg    <= bit_next;
      grant_reg  <= grant_next;
      loaded_reg <= loaded_next;
      oe_n_reg   <= ~(i_oe_en & loaded_next);
    end
  end

  assign o_busy  = (state_reg != IDLE);
  assign o_grant = grant_reg;
  assign o_clk   = (state_reg == SHIFT_HI);
  assign o_latch = (state_reg == LATCH);
  assign o_data  = ((state_reg == SHIFT_LO) | (state_reg == SHIFT_HI)) & shift_reg[0];
  assign o_oe_   = oe_n_reg;

endmodule

// File: tb/tb_hc595_chain_arbiter.sv
// Bench for hc595_chain_arbiter: a cycle model checks every cycle of the 8-bit/div-1
// instance, directed sequences cover corner cases and a 16-bit/div-3 instance.
module tb_hc595_chain_arbiter;

  localparam int NA = 8;
  localparam int DA = 1;
  localparam int NB = 16;
  localparam int DB = 3;
  localparam int LA = 2 * NA * DA + DA;
  localparam int PB = 2 * NB * DB + DB + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, v0, v1, oe_en;
  logic [NA-1:0] d0, d1;
  logic          r0, r1, busy, grant, sclk, latch, sdata, oe_n;

  logic          b_rst, b_v0, b_v1, b_oe_en;
  logic [NB-1:0] b_d0, b_d1;
  logic          b_r0, b_r1, b_busy, b_grant, b_sclk, b_latch, b_sdata, b_oe_n;

  hc595_chain_arbiter #(.CHAIN_BITS(NA), .CLK_DIV(DA)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .i_req0_data(d0), .o_req0_ready(r0),
    .i_req1_valid(v1), .i_req1_data(d1), .o_req1_ready(r1),
    .i_oe_en(oe_en), .o_busy(busy), .o_grant(grant),
    .o_clk(sclk), .o_latch(latch), .o_data(sdata), .o_oe_(oe_n)
  );

  hc595_chain_arbiter #(.CHAIN_BITS(NB), .CLK_DIV(DB)) dut_b (
    .i_clk(clk), .i_rst(b_rst),
    .i_req0_valid(b_v0), .i_req0_data(b_d0), .o_req0_ready(b_r0),
    .i_req1_valid(b_v1), .i_req1_data(b_d1), .o_req1_ready(b_r1),
    .i_oe_en(b_oe_en), .o_busy(b_busy), .o_grant(b_grant),
    .o_clk(b_sclk), .o_latch(b_latch), .o_data(b_sdata), .o_oe_(b_oe_n)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Transaction-level model: a transfer is a window of LA cycles after the handshake.
  bit            mon_en = 1'b0;
  bit            m_active = 1'b0, m_ptr = 1'b0, m_grant = 1'b0, m_loaded = 1'b0, m_oe_n = 1'b1;
  int            m_t0 = 0, m_r = 0, cyc = 0;
  logic [NA-1:0] m_word = '0;
  bit            e_clk, e_data, e_latch, e_r0, e_r1;

  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      e_clk = 1'b0; e_data = 1'b0; e_latch = 1'b0;
      if (m_active) begin
        m_r = cyc - m_t0 - 1;
        if (m_r < 2 * NA * DA) begin
          e_clk  = (m_r % (2 * DA)) >= DA;
          e_data = m_word[m_r / (2 * DA)];
        end else begin
          e_latch = 1'b1;
        end
      end
      e_r0 = !rst && !m_active && v0 && (!v1 || !m_ptr);
      e_r1 = !rst && !m_active && v1 && (!v0 || m_ptr);
      check($sformatf("cycle%0d", cyc),
            {24'b0, r0, r1, busy, grant, sclk, sdata, latch, oe_n},
            {24'b0, e_r0, e_r1, m_active, m_grant, e_clk, e_data, e_latch, m_oe_n});
      if (rst) begin
        m_active = 1'b0; m_ptr = 1'b0; m_grant = 1'b0; m_loaded = 1'b0; m_oe_n = 1'b1;
      end else begin
        if (m_active && m_r == LA - 1) begin
          m_active = 1'b0;
          m_loaded = 1'b1;
        end else if (!m_active && (v0 || v1)) begin
          m_grant  = (v0 && v1) ? m_ptr : v1;
          m_word   = m_grant ? d1 : d0;
          m_t0     = cyc;
          m_active = 1'b1;
          if (v0 && v1) m_ptr = !m_ptr;
        end
        m_oe_n = !(oe_en && m_loaded);
      end
      cyc++;
    end
  end

  // Call just after a negedge; waits (bounded) for the handshake and checks who got it.
  task automatic start_xfer(input bit a0, input bit a1, input logic [NA-1:0] x0,
                            input logic [NA-1:0] x1, input int exp_idx, input string nm,
                            output int n);
    n = 0;
    v0 = a0; v1 = a1; d0 = x0; d1 = x1;
    #1;
    while (!((r0 && v0) || (r1 && v1)) && n < 40) begin
      @(negedge clk); #1; n++;
    end
    check({nm, "_ready"}, {30'b0, r1, r0}, (exp_idx != 0) ? 32'd2 : 32'd1);
  endtask

  task automatic observe(input int ncyc, input bit drop, output logic [NA-1:0] word,
                         output int g1, output int lat_first, output int lat_cnt,
                         output int idle_off, output int oe_low_first, output int oe_low_cnt);
    logic prev_clk;
    int   k;
    word = '0; k = 0; g1 = -1; lat_first = -1; lat_cnt = 0; idle_off = -1;
    oe_low_first = -1; oe_low_cnt = 0; prev_clk = 1'b0;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (drop) begin v0 = 1'b0; v1 = 1'b0; end
      #1;
      if (i == 1) g1 = int'(grant);
      if (sclk && !prev_clk && k < NA) begin word[k] = sdata; k++; end
      prev_clk = sclk;
      if (latch) begin lat_cnt++; if (lat_first < 0) lat_first = i; end
      if (!busy && idle_off < 0) idle_off = i;
      if (!oe_n) begin oe_low_cnt++; if (oe_low_first < 0) oe_low_first = i; end
    end
  endtask

  typedef struct {
    bit            a0;
    bit            a1;
    logic [NA-1:0] x0;
    logic [NA-1:0] x1;
    bit            hold;
    int            idx;
    logic [NA-1:0] w;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [NA-1:0] word;
    logic [NB-1:0] bword;
    int g1, lf, lc, io, of, oc, n;
    int prev, run, minhi, maxhi, minlo, maxlo, k, blc, blf, bio, brdy, bg1, boe;

    tbl[0] = '{1'b1, 1'b1, 8'h0F, 8'hF0, 1'b1, 0, 8'h0F};
    tbl[1] = '{1'b1, 1'b1, 8'h0F, 8'hF0, 1'b1, 1, 8'hF0};
    tbl[2] = '{1'b1, 1'b1, 8'h0F, 8'hF0, 1'b1, 0, 8'h0F};
    tbl[3] = '{1'b1, 1'b1, 8'h0F, 8'hF0, 1'b0, 1, 8'hF0};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 8'h5A, 1'b0, 1, 8'h5A};
    tbl[5] = '{1'b1, 1'b1, 8'h3C, 8'hC3, 1'b0, 0, 8'h3C};
    tbl[6] = '{1'b1, 1'b0, 8'h81, 8'h00, 1'b0, 0, 8'h81};
    tbl[7] = '{1'b1, 1'b1, 8'h7E, 8'hE7, 1'b0, 1, 8'hE7};

    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; oe_en = 1'b1;
    b_rst = 1'b1; b_v0 = 1'b0; b_v1 = 1'b0; b_d0 = '0; b_d1 = '0; b_oe_en = 1'b1;
    @(posedge clk);
    mon_en = 1'b1;

    // Reset held three cycles with both requesters asking.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      v0 = 1'b1; v1 = 1'b1;
      #1;
      check($sformatf("reset_outs%0d", i), {25'b0, r0, r1, busy, sclk, latch, sdata, oe_n}, 32'd1);
    end
    @(negedge clk);
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    #1;
    check("rel_no_valid_ready", {31'b0, r0}, 32'd0);

    // Single write of A5 from req0.
    start_xfer(1'b1, 1'b0, 8'hA5, 8'h00, 0, "single", n);
    observe(20, 1'b1, word, g1, lf, lc, io, of, oc);
    check("single_word", {24'b0, word}, 32'hA5);
    check("single_grant", g1, 0);
    check("single_latch_at", lf, 17);
    check("single_latch_cnt", lc, 1);
    check("single_idle_at", io, 18);
    check("single_oe_low_at", of, 18);

    // Arbitration table: grants, captured words, back-to-back spacing.
    for (int i = 0; i < 8; i++) begin
      start_xfer(tbl[i].a0, tbl[i].a1, tbl[i].x0, tbl[i].x1, tbl[i].idx, $sformatf("tbl%0d", i), n);
      check($sformatf("tbl%0d_wait", i), n, 0);
      observe(18, !tbl[i].hold, word, g1, lf, lc, io, of, oc);
      check($sformatf("tbl%0d_word", i), {24'b0, word}, {24'b0, tbl[i].w});
      check($sformatf("tbl%0d_grant", i), g1, tbl[i].idx);
      check($sformatf("tbl%0d_latch_at", i), lf, 17);
    end

    // Reset in the middle of shifting.
    start_xfer(1'b1, 1'b0, 8'hFF, 8'h00, 0, "mid", n);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      v0 = 1'b0;
      if (i == 5) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_outs", {27'b0, sclk, latch, sdata, busy, oe_n}, 32'd1);
    observe(14, 1'b1, word, g1, lf, lc, io, of, oc);
    check("mid_rst_no_latch", lc, 0);
    start_xfer(1'b0, 1'b1, 8'h00, 8'h3C, 1, "after_rst", n);
    observe(20, 1'b1, word, g1, lf, lc, io, of, oc);
    check("after_rst_word", {24'b0, word}, 32'h3C);
    check("after_rst_grant", g1, 1);
    check("after_rst_latch_at", lf, 17);

    // Output enable gating.
    oe_en = 1'b0;
    start_xfer(1'b1, 1'b0, 8'h11, 8'h00, 0, "oe_x0", n);
    observe(18, 1'b1, word, g1, lf, lc, io, of, oc);
    check("oe_x0_low_cnt", oc, 0);
    start_xfer(1'b0, 1'b1, 8'h00, 8'h22, 1, "oe_x1", n);
    observe(20, 1'b1, word, g1, lf, lc, io, of, oc);
    check("oe_x1_low_cnt", oc, 0);
    oe_en = 1'b1;
    @(negedge clk); #1;
    check("oe_enable", {31'b0, oe_n}, 32'd0);
    oe_en = 1'b0;
    @(negedge clk); #1;
    check("oe_disable", {31'b0, oe_n}, 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 199) == 0);
      v0    = ($urandom_range(0, 3) != 0);
      v1    = ($urandom_range(0, 2) != 0);
      d0    = NA'($urandom);
      d1    = NA'($urandom);
      oe_en = ($urandom_range(0, 15) != 0);
    end
    @(negedge clk);
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    repeat (30) @(negedge clk);

    // Wide chain, divided shift clock.
    b_rst = 1'b0;
    @(negedge clk);
    b_v0 = 1'b1; b_d0 = 16'h8001;
    #1;
    check("b_ready", {31'b0, b_r0}, 32'd1);
    bword = '0; k = 0; run = 0; prev = 0; minhi = 99; maxhi = 0; minlo = 99; maxlo = 0;
    blc = 0; blf = -1; bio = -1; brdy = -1; bg1 = -1; boe = -1;
    for (int i = 1; i <= PB; i++) begin
      @(negedge clk); #1;
      if (i == 1) begin
        bg1 = int'(b_grant); prev = int'(b_sclk); run = 1;
      end else if (int'(b_sclk) == prev) begin
        run++;
      end else begin
        if (prev != 0) begin
          minhi = (run < minhi) ? run : minhi; maxhi = (run > maxhi) ? run : maxhi;
        end else begin
          minlo = (run < minlo) ? run : minlo; maxlo = (run > maxlo) ? run : maxlo;
        end
        prev = int'(b_sclk); run = 1;
      end
      if (b_sclk && run == 1 && k < NB) begin bword[k] = b_sdata; k++; end
      if (b_latch) begin blc++; if (blf < 0) blf = i; end
      if (!b_busy && bio < 0) bio = i;
      if (b_r0 && brdy < 0) brdy = i;
      if (i == PB) boe = int'(b_oe_n);
    end
    b_v0 = 1'b0;
    check("b_word", {16'b0, bword}, 32'h8001);
    check("b_grant", bg1, 0);
    check("b_hi_min", minhi, DB);
    check("b_hi_max", maxhi, DB);
    check("b_lo_min", minlo, DB);
    check("b_lo_max", maxlo, DB);
    check("b_latch_cnt", blc, DB);
    check("b_latch_at", blf, 2 * NB * DB + 1);
    check("b_idle_at", bio, PB);
    check("b_next_ready_at", brdy, PB);
    check("b_oe_low", boe, 0);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
